reg_check_monitor: RTL and testbench
====================================

// Module: reg_check_monitor
// PURPOSE
//   Synthesizable regfile self-check for the whack-a-mole processor.
//   Programmable table of NUM_CHECKS (register, expected value) entries.
//   On start: waits WAIT_CYCLES clocks, then compares one entry per cycle
//   against live register probes.
//   Reports per-mismatch detail, a saturating error count, and pass/done.
//   Sits beside skeleton's regfile; outputs can drive LEDs/debug on-board.
// PARAMETERS
//   NUM_REGS     32  registers exposed on reg_flat
//   DATA_W       32  register width
//   NUM_CHECKS   8   table depth (>=1)
//   WAIT_CYCLES  42  settle cycles after start before checking (0 allowed)
//   ERR_W        8   error_count width, saturating
// PORTS
//   clock         in   1                    system clock, rising edge
//   reset         in   1                    async, active-low; asserted=0
//   start         in   1                    begin run; sampled in IDLE/DONE only
//   reg_flat      in   NUM_REGS*DATA_W      reg r at [r*DATA_W +: DATA_W]
//   cfg_we        in   1                    table write strobe
//   cfg_idx       in   clog2(NUM_CHECKS)    table entry index
//   cfg_valid     in   1                    entry enable
//   cfg_reg       in   5                    register number to check
//   cfg_val       in   DATA_W               expected value
//   busy          out  1                    in WAIT or CHECK
//   done          out  1                    run finished; held until next start
//   pass          out  1                    done && error_count==0
//   error_count   out  ERR_W                mismatches this run
//   fail_valid    out  1                    1-cycle pulse per mismatch
//   fail_reg      out  5                    failing register number
//   fail_read     out  DATA_W               value read
//   fail_expected out  DATA_W               value expected
// BEHAVIOUR
//   Reset (reset=0, async): FSM=IDLE; all outputs 0; table valid bits cleared.
//   FSM: IDLE -start-> WAIT (or CHECK if WAIT_CYCLES==0).
//     WAIT: WAIT_CYCLES cycles -> CHECK.
//     CHECK: idx 0..NUM_CHECKS-1, one per cycle; after last -> DONE.
//     DONE -start-> WAIT/CHECK.
//   start: clears error_count, done, pass on the sampling edge.
//     start while busy is ignored.
//   Latency: done rises WAIT_CYCLES+NUM_CHECKS+1 edges after the start edge.
//     Invalid entries still consume their cycle, so latency is fixed.
//   Compare: mismatch = valid && (read != expected).
//     cfg_reg >= NUM_REGS is a mismatch with fail_read = 0.
//   Mismatch reporting: fail_* registered 1 cycle after the compare cycle.
//     fail_valid is a 1-cycle pulse; fail_* data hold until the next mismatch.
//   error_count: +1 per mismatch; saturates at 2^ERR_W-1, never wraps.
//   cfg_we: accepted in IDLE/DONE only, ignored while busy.
//     Writes take effect on the next run.
//   Reset mid-run aborts immediately; the next run needs start.
// CONFIGURATION
//   REG_CHECK_MASK_EN defined:
//     Adds input cfg_mask [DATA_W] stored per entry.
//     mismatch = valid && ((read ^ expected) & mask) != 0.
//     fail_read/fail_expected are reported unmasked.
//   Undefined:
//     No cfg_mask port; full-width compare.
// TESTING
//   1. Reset, r1=5, entry0={v,1,5}, start -> done at edge 51
//      (42+8+1); pass=1, error_count=0, fail_valid never pulses.
//   2. entry3={v,2,7}, r2=9 -> fail_valid once; fail_reg=2, fail_read=9,
//      fail_expected=7; error_count=1, pass=0.
//   3. ERR_W=2, 8 valid mismatching entries -> error_count=3 (saturated);
//      8 fail_valid pulses.
//   4. start and cfg_we mid-WAIT -> ignored; done latency unchanged;
//      table unchanged.
//   5. reset=0 during CHECK -> busy=done=error_count=0 immediately;
//      stays IDLE until start.
//   6. MASK_EN: mask=0xFFFF0000, exp=0x1234_0000, read=0x1234_ABCD -> no error;
//      entry cfg_reg=31 with NUM_REGS=16 -> mismatch, fail_read=0.

Source files
------------

// File: rtl/reg_check_monitor.sv
// Register-file self-check: after start, waits WAIT_CYCLES clocks, then compares
// one programmed table entry per cycle against live register probes.
// Optional per-entry compare mask when REG_CHECK_MASK_EN is defined.
module reg_check_monitor #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_CHECKS  = 8,
    parameter int unsigned WAIT_CYCLES = 42,
    parameter int unsigned ERR_W       = 8,
    localparam int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_valid,
    input  logic [4:0]                 cfg_reg,
    input  logic [DATA_W-1:0]          cfg_val,
`ifdef REG_CHECK_MASK_EN
    input  logic [DATA_W-1:0]          cfg_mask,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           error_count,
    output logic                       fail_valid,
    output logic [4:0]                 fail_reg,
    output logic [DATA_W-1:0]          fail_read,
    output logic [DATA_W-1:0]          fail_expected
);

    localparam int unsigned CNT_MAX = (WAIT_CYCLES > NUM_CHECKS) ? WAIT_CYCLES : NUM_CHECKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                fail_valid_q, fail_valid_d;
    logic [4:0]          fail_reg_q, fail_reg_d;
    logic [DATA_W-1:0]   fail_read_q, fail_read_d;
    logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;

    logic [NUM_CHECKS-1:0] tbl_valid_q;
    logic [4:0]            tbl_reg_q [NUM_CHECKS];
    logic [DATA_W-1:0]     tbl_val_q [NUM_CHECKS];
`ifdef REG_CHECK_MASK_EN
    logic [DATA_W-1:0]     tbl_mask_q [NUM_CHECKS];
`endif

    logic              idle_like, tbl_we;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_valid, in_range, mismatch;
    logic [4:0]        cur_reg;
    logic [DATA_W-1:0] cur_val, cur_read, cur_mask;

    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign tbl_we    = cfg_we && idle_like && (32'(cfg_idx) < NUM_CHECKS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tbl_valid_q <= '0;
        end else if (tbl_we) begin
            tbl_valid_q[cfg_idx] <= cfg_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (tbl_we) begin
            tbl_reg_q[cfg_idx] <= cfg_reg;
            tbl_val_q[cfg_idx] <= cfg_val;
`ifdef REG_CHECK_MASK_EN
            tbl_mask_q[cfg_idx] <= cfg_mask;
`endif
        end
    end

    // The counter doubles as the table index while checking.
    assign cur_idx   = IDX_W'(cnt_q);
    assign cur_valid = tbl_valid_q[cur_idx];
    assign cur_reg   = tbl_reg_q[cur_idx];
    assign cur_val   = tbl_val_q[cur_idx];
`ifdef REG_CHECK_MASK_EN
    assign cur_mask  = tbl_mask_q[cur_idx];
`else
    assign cur_mask  = '1;
`endif
    assign in_range  = 32'(cur_reg) < NUM_REGS;

    always_comb begin
        cur_read = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (cur_reg == 5'(r)) cur_read = reg_flat[r*DATA_W +: DATA_W];
        end
    end

    assign mismatch = cur_valid && (!in_range || (((cur_read ^ cur_val) & cur_mask) != '0));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = 1'b0;
        fail_reg_d   = fail_reg_q;
        fail_read_d  = fail_read_q;
        fail_exp_d   = fail_exp_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    err_d   = '0;
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES == 0) ? StCheck : StWait;
                end
            end
            StWait: begin
                if (32'(cnt_q) == WAIT_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCheck: begin
                // One trailing cycle after the last entry keeps latency at W+N+1.
                if (32'(cnt_q) == NUM_CHECKS) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        fail_valid_d = 1'b1;
                        fail_reg_d   = cur_reg;
                        fail_read_d  = cur_read;
                        fail_exp_d   = cur_val;
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_reg_q   <= '0;
            fail_read_q  <= '0;
            fail_exp_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_reg_q   <= fail_reg_d;
            fail_read_q  <= fail_read_d;
            fail_exp_q   <= fail_exp_d;
        end
    end

    assign busy          = (state_q == StWait) || (state_q == StCheck);
    assign done          = (state_q == StDone);
    assign pass          = done && (err_q == '0);
    assign error_count   = err_q;
    assign fail_valid    = fail_valid_q;
    assign fail_reg      = fail_reg_q;
    assign fail_read     = fail_read_q;
    assign fail_expected = fail_exp_q;

endmodule

// File: tb/tb_reg_check_monitor.sv
// Self-checking bench for reg_check_monitor: directed scenarios plus randomized
// tables checked against a list-based reference model.
module tb_reg_check_monitor;

    localparam int NUM_REGS    = 16;
    localparam int DATA_W      = 32;
    localparam int NUM_CHECKS  = 8;
    localparam int WAIT_CYCLES = 42;
    localparam int ERR_W       = 3;
    localparam int IDX_W       = 3;
    localparam int LAT         = WAIT_CYCLES + NUM_CHECKS + 1;
    localparam int SAT         = (1 << ERR_W) - 1;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic                       start = 1'b0;
    logic [NUM_REGS*DATA_W-1:0] reg_flat;
    logic                       cfg_we = 1'b0;
    logic [IDX_W-1:0]           cfg_idx = '0;
    logic                       cfg_valid = 1'b0;
    logic [4:0]                 cfg_reg = '0;
    logic [DATA_W-1:0]          cfg_val = '0;
`ifdef REG_CHECK_MASK_EN
    logic [DATA_W-1:0]          cfg_mask = '0;
`endif
    logic                       busy, done, pass, fail_valid;
    logic [ERR_W-1:0]           error_count;
    logic [4:0]                 fail_reg;
    logic [DATA_W-1:0]          fail_read, fail_expected;

    reg_check_monitor #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .NUM_CHECKS(NUM_CHECKS),
        .WAIT_CYCLES(WAIT_CYCLES), .ERR_W(ERR_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .reg_flat(reg_flat),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_reg(cfg_reg),
        .cfg_val(cfg_val),
`ifdef REG_CHECK_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .fail_valid(fail_valid), .fail_reg(fail_reg), .fail_read(fail_read),
        .fail_expected(fail_expected)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] regs [NUM_REGS];
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) reg_flat[r*DATA_W +: DATA_W] = regs[r];
    end

    // Reference table and expected / observed mismatch lists
    bit                m_valid [NUM_CHECKS];
    int                m_reg   [NUM_CHECKS];
    logic [DATA_W-1:0] m_val   [NUM_CHECKS];
    logic [DATA_W-1:0] m_mask  [NUM_CHECKS];
    int                e_reg[$], o_reg[$];
    logic [DATA_W-1:0] e_read[$], e_exp[$], o_read[$], o_exp[$];

    int n_cmp = 0;
    int n_fail = 0;
    int de;
    bit bok;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic rand_regs;
        for (int r = 0; r < NUM_REGS; r++) regs[r] = $urandom;
    endtask

    task automatic cfg_write(input int idx, input bit v, input int r,
                             input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] mask,
                             input bit taken);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_valid = v; cfg_reg = 5'(r); cfg_val = val;
`ifdef REG_CHECK_MASK_EN
        cfg_mask = mask;
`endif
        tick;
        cfg_we = 1'b0;
        if (taken) begin
            m_valid[idx] = v; m_reg[idx] = r; m_val[idx] = val;
`ifdef REG_CHECK_MASK_EN
            m_mask[idx] = mask;
`else
            m_mask[idx] = '1;
`endif
        end
    endtask

    function automatic void model_run();
        logic [DATA_W-1:0] rd;
        e_reg.delete(); e_read.delete(); e_exp.delete();
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (m_valid[i]) begin
                rd = (m_reg[i] < NUM_REGS) ? regs[m_reg[i]] : '0;
                if (m_reg[i] >= NUM_REGS || ((rd ^ m_val[i]) & m_mask[i]) != 0) begin
                    e_reg.push_back(m_reg[i]); e_read.push_back(rd); e_exp.push_back(m_val[i]);
                end
            end
        end
    endfunction

    // Starts a run, records fail pulses; poke drives start and cfg_we mid-WAIT.
    task automatic do_run(input bit poke, output int done_edge, output bit busy_ok);
        o_reg.delete(); o_read.delete(); o_exp.delete();
        done_edge = -1; busy_ok = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int e = 1; e <= LAT + 20; e++) begin
            tick;
            if (poke && e == 11) begin start = 1'b0; cfg_we = 1'b0; end
            if (fail_valid) begin
                o_reg.push_back(int'(fail_reg)); o_read.push_back(fail_read);
                o_exp.push_back(fail_expected);
            end
            if (done) begin done_edge = e; break; end
            if (!busy) busy_ok = 1'b0;
            if (poke && e == 10) begin
                start = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_valid = ~m_valid[0];
                cfg_reg = 5'(m_reg[0] + 1); cfg_val = ~m_val[0];
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) tick;
        n_cmp++;
        if ({busy, done, pass, error_count, fail_valid, fail_reg, fail_read, fail_expected} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d fv=%b freg=%0d got nonzero",
                     busy, done, pass, error_count, fail_valid, fail_reg);
        end
        #2 reset = 1'b1;
        repeat (5) tick;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < NUM_CHECKS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic test_basic_pass;
        rand_regs();
        regs[1] = 5;
        cfg_write(0, 1'b1, 1, 5, '1, 1'b1);
        do_run(1'b0, de, bok);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", de, LAT); end
        n_cmp++; if (!bok) begin n_fail++; $display("FAIL basic_busy: got 0 want 1 during run"); end
        n_cmp++; if (o_reg.size() != 0) begin n_fail++; $display("FAIL basic_pulses: got %0d want 0", o_reg.size()); end
        n_cmp++; if (error_count !== 0) begin n_fail++; $display("FAIL basic_err: got %0d want 0", error_count); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL basic_pass: got %b want 1", pass); end
    endtask

    task automatic test_single_mismatch;
        regs[2] = 9;
        cfg_write(3, 1'b1, 2, 7, '1, 1'b1);
        do_run(1'b0, de, bok);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", de, LAT); end
        n_cmp++;
        if (o_reg.size() != 1 || o_reg[0] != 2 || o_read[0] !== 9 || o_exp[0] !== 7) begin
            n_fail++; $display("FAIL single_pulse: got n=%0d reg=%0d read=%0d exp=%0d want n=1 2 9 7",
                               o_reg.size(), o_reg.size() ? o_reg[0] : -1, fail_read, fail_expected);
        end
        n_cmp++; if (error_count !== 1) begin n_fail++; $display("FAIL single_err: got %0d want 1", error_count); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL single_pass: got %b want 0", pass); end
        n_cmp++;
        if ({fail_reg, fail_read, fail_expected} !== {5'd2, 32'd9, 32'd7}) begin
            n_fail++; $display("FAIL single_hold: got %0d/%0d/%0d want 2/9/7", fail_reg, fail_read, fail_expected);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < NUM_CHECKS; i++) cfg_write(i, 1'b1, i, ~regs[i], '1, 1'b1);
        model_run();
        do_run(1'b0, de, bok);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL sat_latency: got %0d want %0d", de, LAT); end
        n_cmp++; if (o_reg.size() != NUM_CHECKS) begin n_fail++; $display("FAIL sat_pulses: got %0d want %0d", o_reg.size(), NUM_CHECKS); end
        foreach (e_reg[i]) begin
            n_cmp++;
            if (i >= o_reg.size() || o_reg[i] != e_reg[i] || o_read[i] !== e_read[i] || o_exp[i] !== e_exp[i]) begin
                n_fail++; $display("FAIL sat_entry%0d: got reg %0d want %0d", i, (i < o_reg.size()) ? o_reg[i] : -1, e_reg[i]);
            end
        end
        n_cmp++; if (error_count !== SAT) begin n_fail++; $display("FAIL sat_err: got %0d want %0d", error_count, SAT); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b want 0", pass); end
    endtask

    task automatic test_busy_ignore;
        model_run();
        do_run(1'b1, de, bok);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", de, LAT); end
        n_cmp++; if (!bok) begin n_fail++; $display("FAIL ignore_busy: got 0 want 1 during run"); end
        n_cmp++; if (o_reg.size() != e_reg.size()) begin n_fail++; $display("FAIL ignore_pulses: got %0d want %0d", o_reg.size(), e_reg.size()); end
        foreach (e_reg[i]) begin
            n_cmp++;
            if (i >= o_reg.size() || o_reg[i] != e_reg[i] || o_read[i] !== e_read[i] || o_exp[i] !== e_exp[i]) begin
                n_fail++; $display("FAIL ignore_entry%0d: got reg %0d want %0d", i, (i < o_reg.size()) ? o_reg[i] : -1, e_reg[i]);
            end
        end
        n_cmp++; if (error_count !== SAT) begin n_fail++; $display("FAIL ignore_err: got %0d want %0d", error_count, SAT); end
    endtask

    task automatic test_abort;
        bit stuck;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (WAIT_CYCLES + 4) tick;
        n_cmp++;
        if ({busy, error_count} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL abort_precheck: got busy=%b err=%0d want 1 4", busy, error_count);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, error_count, fail_valid, pass} !== '0) begin
            n_fail++; $display("FAIL abort_clear: got busy=%b done=%b err=%0d fv=%b want all 0",
                               busy, done, error_count, fail_valid);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < NUM_CHECKS; i++) m_valid[i] = 1'b0;
        stuck = 1'b0;
        repeat (60) begin tick; if (busy || done) stuck = 1'b1; end
        n_cmp++; if (stuck) begin n_fail++; $display("FAIL abort_idle: got busy/done activity want none"); end
        rand_regs();
        do_run(1'b0, de, bok);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d want %0d", de, LAT); end
        n_cmp++;
        if (o_reg.size() != 0 || pass !== 1'b1) begin
            n_fail++; $display("FAIL abort_table_cleared: got pulses=%0d pass=%b want 0 1", o_reg.size(), pass);
        end
    endtask

    task automatic test_out_of_range;
        rand_regs();
        for (int i = 0; i < NUM_CHECKS; i++) cfg_write(i, 1'b0, 0, 0, '1, 1'b1);
        cfg_write(5, 1'b1, 31, $urandom, '1, 1'b1);
        cfg_write(6, 1'b1, 16, 0, '1, 1'b1);
        cfg_write(7, 1'b1, 15, regs[15], '1, 1'b1);
        model_run();
        do_run(1'b0, de, bok);
        n_cmp++; if (o_reg.size() != e_reg.size()) begin n_fail++; $display("FAIL oor_pulses: got %0d want %0d", o_reg.size(), e_reg.size()); end
        foreach (e_reg[i]) begin
            n_cmp++;
            if (i >= o_reg.size() || o_reg[i] != e_reg[i] || o_read[i] !== e_read[i] || o_exp[i] !== e_exp[i]) begin
                n_fail++; $display("FAIL oor_entry%0d: got reg %0d read %h want reg %0d read %h", i,
                                   (i < o_reg.size()) ? o_reg[i] : -1, (i < o_read.size()) ? o_read[i] : '1,
                                   e_reg[i], e_read[i]);
            end
        end
        n_cmp++; if (error_count !== 2) begin n_fail++; $display("FAIL oor_err: got %0d want 2", error_count); end
    endtask

`ifdef REG_CHECK_MASK_EN
    task automatic test_mask;
        rand_regs();
        regs[3] = 32'h1234_ABCD;
        for (int i = 0; i < NUM_CHECKS; i++) cfg_write(i, 1'b0, 0, 0, '1, 1'b1);
        cfg_write(0, 1'b1, 3, 32'h1234_0000, 32'hFFFF_0000, 1'b1);
        cfg_write(1, 1'b1, 3, 32'h1234_0000, 32'h0000_FFFF, 1'b1);
        do_run(1'b0, de, bok);
        n_cmp++;
        if (o_reg.size() != 1 || o_reg[0] != 3 || o_read[0] !== 32'h1234_ABCD || o_exp[0] !== 32'h1234_0000) begin
            n_fail++; $display("FAIL mask_pulse: got n=%0d read=%h exp=%h want n=1 1234abcd 12340000",
                               o_reg.size(), fail_read, fail_expected);
        end
        n_cmp++; if (error_count !== 1) begin n_fail++; $display("FAIL mask_err: got %0d want 1", error_count); end
    endtask
`endif

    task automatic test_random;
        int r;
        logic [DATA_W-1:0] v;
        for (int run = 0; run < 6; run++) begin
            rand_regs();
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r = $urandom_range(0, 20);
                v = (r < NUM_REGS && $urandom_range(0, 1) == 1) ? regs[r] : $urandom;
                cfg_write(i, 1'($urandom_range(0, 1)), r, v, $urandom | 32'h1, 1'b1);
            end
            model_run();
            do_run(1'b0, de, bok);
            n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", run, de, LAT); end
            n_cmp++; if (o_reg.size() != e_reg.size()) begin n_fail++; $display("FAIL rand%0d_pulses: got %0d want %0d", run, o_reg.size(), e_reg.size()); end
            foreach (e_reg[i]) begin
                n_cmp++;
                if (i >= o_reg.size() || o_reg[i] != e_reg[i] || o_read[i] !== e_read[i] || o_exp[i] !== e_exp[i]) begin
                    n_fail++; $display("FAIL rand%0d_entry%0d: got reg %0d want %0d", run, i,
                                       (i < o_reg.size()) ? o_reg[i] : -1, e_reg[i]);
                end
            end
            n_cmp++;
            if (error_count !== ERR_W'((e_reg.size() > SAT) ? SAT : e_reg.size())) begin
                n_fail++; $display("FAIL rand%0d_err: got %0d want %0d", run, error_count, e_reg.size());
            end
            n_cmp++;
            if (pass !== (e_reg.size() == 0)) begin
                n_fail++; $display("FAIL rand%0d_pass: got %b want %b", run, pass, e_reg.size() == 0);
            end
        end
    endtask

    initial begin
        rand_regs();
        test_reset();
        test_basic_pass();
        test_single_mismatch();
        test_saturation();
        test_busy_ignore();
        test_abort();
        test_out_of_range();
`ifdef REG_CHECK_MASK_EN
        test_mask();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
